acionador_motores: RTL and testbench

ACIONADOR_MOTORES -- requirements
Module: acionador_motores

---
 rtl/acionador_pkg.sv | 34 +++
 rtl/acionador_motores_contador_tempo.sv | 27 ++
 rtl/acionador_motores.sv | 105 ++++++++++
 tb/tb_acionador_motores.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/acionador_pkg.sv
// rtl/acionador_pkg.sv - shared states, motor codes and counter width for the motor driver
package acionador_pkg;

  localparam int LARGURA_CONT = 16;

  typedef enum logic [2:0] {
    OCIOSO,
    AVANCA,
    GIRA,
    CURVA,
    REMOVE,
    MORTO
  } estado_t;

  typedef enum logic [1:0] {
    PARADO = 2'b00,
    FRENTE = 2'b01,
    TRAS   = 2'b10
  } motor_t;

  // The left wheel drives forward in every motion; only the right wheel tells them apart.
  function automatic motor_t motor_esq(input estado_t e);
    return (e == AVANCA || e == GIRA || e == CURVA) ? FRENTE : PARADO;
  endfunction

  function automatic motor_t motor_dir(input estado_t e);
    case (e)
      AVANCA:  return FRENTE;
      GIRA:    return TRAS;
      default: return PARADO;
    endcase
  endfunction

endpackage

// File: rtl/acionador_motores_contador_tempo.sv
// rtl/acionador_motores_contador_tempo.sv - loadable down-counter timing each motion and dead time
module contador_tempo
  import acionador_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    carga,
  input  logic                    habilita,
  input  logic [LARGURA_CONT-1:0] valor,
  output logic                    zero
);

  logic [LARGURA_CONT-1:0] cont;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont <= '0;
    end else if (carga) begin
      cont <= valor;
    end else if (habilita && cont != '0) begin
      cont <= cont - LARGURA_CONT'(1);
    end
  end

  assign zero = (cont == '0);

endmodule

// File: rtl/acionador_motores.sv
// rtl/acionador_motores.sv - timed motor/arm sequencer driven by forward, turn and remove commands
module acionador_motores
  import acionador_pkg::*;
#(
  parameter int T_AVANCO  = 8,
  parameter int T_GIRO    = 6,
  parameter int T_CURVA   = 6,
  parameter int T_REMOCAO = 10,
  parameter int T_MORTO   = 2
) (
  input  logic       clockc2,
  input  logic       reset,
  input  logic       avancar,
  input  logic       girar,
  input  logic       remover,
  output logic [1:0] mot_esq,
  output logic [1:0] mot_dir,
  output logic       braco,
  output logic       ocupado,
  output logic       concluido
);

  if (T_AVANCO < 1 || T_AVANCO > 65535 || T_GIRO < 1 || T_GIRO > 65535 ||
      T_CURVA < 1 || T_CURVA > 65535 || T_REMOCAO < 1 || T_REMOCAO > 65535 ||
      T_MORTO < 0 || T_MORTO > 65535) begin : g_parametro_invalido
    $error("acionador_motores: motion times must be 1..65535 and dead time 0..65535");
  end

  // Counter holds T-1 on entry so the zero flag marks the last cycle of the phase.
  localparam logic [LARGURA_CONT-1:0] V_AVANCO  = LARGURA_CONT'(T_AVANCO - 1);
  localparam logic [LARGURA_CONT-1:0] V_GIRO    = LARGURA_CONT'(T_GIRO - 1);
  localparam logic [LARGURA_CONT-1:0] V_CURVA   = LARGURA_CONT'(T_CURVA - 1);
  localparam logic [LARGURA_CONT-1:0] V_REMOCAO = LARGURA_CONT'(T_REMOCAO - 1);
  localparam logic [LARGURA_CONT-1:0] V_MORTO   = LARGURA_CONT'(T_MORTO - 1);

  estado_t                 estado;
  estado_t                 prox;
  logic                    carga;
  logic                    habilita;
  logic [LARGURA_CONT-1:0] valor;
  logic                    zero;

  contador_tempo u_contador (
    .clk      (clockc2),
    .rst      (reset),
    .carga    (carga),
    .habilita (habilita),
    .valor    (valor),
    .zero     (zero)
  );

  always_comb begin
    prox     = estado;
    carga    = 1'b0;
    habilita = 1'b0;
    valor    = '0;
    case (estado)
      OCIOSO: begin
        if (remover) begin
          prox = REMOVE; carga = 1'b1; valor = V_REMOCAO;
        end else if (avancar && girar) begin
          prox = CURVA; carga = 1'b1; valor = V_CURVA;
        end else if (girar) begin
          prox = GIRA; carga = 1'b1; valor = V_GIRO;
        end else if (avancar) begin
          prox = AVANCA; carga = 1'b1; valor = V_AVANCO;
        end
      end
      AVANCA, GIRA, CURVA, REMOVE: begin
        if (!zero) begin
          habilita = 1'b1;
        end else if (T_MORTO > 0) begin
          prox = MORTO; carga = 1'b1; valor = V_MORTO;
        end else begin
          prox = OCIOSO;
        end
      end
      MORTO: begin
        if (!zero) habilita = 1'b1;
        else       prox = OCIOSO;
      end
      default: prox = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clockc2 or posedge reset) begin
    if (reset) begin
      estado    <= OCIOSO;
      mot_esq   <= PARADO;
      mot_dir   <= PARADO;
      braco     <= 1'b0;
      ocupado   <= 1'b0;
      concluido <= 1'b0;
    end else begin
      estado    <= prox;
      mot_esq   <= motor_esq(prox);
      mot_dir   <= motor_dir(prox);
      braco     <= (prox == REMOVE);
      ocupado   <= (prox != OCIOSO);
      concluido <= (prox == OCIOSO) && (estado != OCIOSO);
    end
  end

endmodule

// File: tb/tb_acionador_motores.sv
// tb/tb_acionador_motores.sv - scoreboard bench for the motor driver with short timing parameters
module tb_acionador_motores;

  logic       clockc2 = 1'b0;
  logic       reset = 1'b1;
  logic       avancar = 1'b0;
  logic       girar = 1'b0;
  logic       remover = 1'b0;
  logic [1:0] mot_esq;
  logic [1:0] mot_dir;
  logic       braco;
  logic       ocupado;
  logic       concluido;

  acionador_motores #(
    .T_AVANCO(4), .T_GIRO(3), .T_CURVA(3), .T_REMOCAO(5), .T_MORTO(2)
  ) dut (
    .clockc2   (clockc2),
    .reset     (reset),
    .avancar   (avancar),
    .girar     (girar),
    .remover   (remover),
    .mot_esq   (mot_esq),
    .mot_dir   (mot_dir),
    .braco     (braco),
    .ocupado   (ocupado),
    .concluido (concluido)
  );

  always #5 clockc2 = ~clockc2;

  // {mot_esq, mot_dir, braco, ocupado, concluido}
  localparam logic [6:0] OCI = 7'b00_00_0_0_0;
  localparam logic [6:0] CON = 7'b00_00_0_0_1;
  localparam logic [6:0] AV  = 7'b01_01_0_1_0;
  localparam logic [6:0] GI  = 7'b01_10_0_1_0;
  localparam logic [6:0] CU  = 7'b01_00_0_1_0;
  localparam logic [6:0] RM  = 7'b00_00_1_1_0;
  localparam logic [6:0] MO  = 7'b00_00_0_1_0;

  logic [6:0] exp_q[$];
  string      nome_q[$];
  int         checks = 0;
  int         errors = 0;
  event       amostra;

  initial begin
    logic [6:0] esperado;
    logic [6:0] obs;
    string      nome;
    forever begin
      @(posedge clockc2 or amostra);
      #1;
      if (exp_q.size() > 0) begin
        esperado = exp_q.pop_front();
        nome     = nome_q.pop_front();
        obs      = {mot_esq, mot_dir, braco, ocupado, concluido};
        checks++;
        if (obs !== esperado) begin
          errors++;
          $display("FAIL %s: got %b required %b", nome, obs, esperado);
        end
      end
    end
  end

  task automatic tick(input logic a, input logic g, input logic r, input logic rs,
                      input logic [6:0] e, input string n);
    @(negedge clockc2);
    avancar = a; girar = g; remover = r; reset = rs;
    exp_q.push_back(e);
    nome_q.push_back(n);
  endtask

  task automatic reset_assincrono();
    @(negedge clockc2);
    reset = 1'b1;
    #1;
    exp_q.push_back(OCI);
    nome_q.push_back("async_reset");
    -> amostra;
    #2;
  endtask

  initial begin
    tick(0, 0, 0, 1, OCI, "reset_state");
    tick(0, 0, 0, 1, OCI, "reset_state");
    tick(0, 0, 0, 0, OCI, "idle_no_cmd");

    // forward: 4 motion + 2 dead time, one completion pulse
    tick(1, 0, 0, 0, AV, "avanca");
    repeat (3) tick(0, 0, 0, 0, AV, "avanca");
    repeat (2) tick(0, 0, 0, 0, MO, "avanca_morto");
    tick(0, 0, 0, 0, CON, "avanca_concluido");
    tick(0, 0, 0, 0, OCI, "avanca_idle");

    // all three commands: remove wins
    tick(1, 1, 1, 0, RM, "remove");
    repeat (4) tick(0, 0, 0, 0, RM, "remove");
    repeat (2) tick(0, 0, 0, 0, MO, "remove_morto");
    tick(0, 0, 0, 0, CON, "remove_concluido");
    tick(0, 0, 0, 0, OCI, "remove_idle");

    // curve with inputs toggled mid-motion and during dead time
    tick(1, 1, 0, 0, CU, "curva");
    tick(0, 0, 1, 0, CU, "curva_ignora");
    tick(1, 0, 0, 0, CU, "curva_ignora");
    tick(0, 1, 0, 0, MO, "curva_morto_ignora");
    tick(0, 0, 1, 0, MO, "curva_morto_ignora");
    tick(0, 0, 0, 0, CON, "curva_concluido");
    tick(0, 0, 0, 0, OCI, "curva_idle");

    // girar held: a new run starts on the edge where concluido is high
    repeat (2) begin
      repeat (3) tick(0, 1, 0, 0, GI, "gira_continuo");
      repeat (2) tick(0, 1, 0, 0, MO, "gira_morto");
      tick(0, 1, 0, 0, CON, "gira_concluido");
    end
    tick(0, 0, 0, 0, OCI, "gira_fim");

    // reset in the second forward cycle aborts without a completion pulse
    tick(1, 0, 0, 0, AV, "avanca_pre_reset");
    tick(0, 0, 0, 0, AV, "avanca_pre_reset");
    reset_assincrono();
    tick(0, 0, 0, 1, OCI, "reset_held");
    tick(1, 0, 0, 0, AV, "avanca_pos_reset");
    repeat (3) tick(0, 0, 0, 0, AV, "avanca_pos_reset");
    repeat (2) tick(0, 0, 0, 0, MO, "pos_reset_morto");
    tick(0, 0, 0, 0, CON, "pos_reset_concluido");
    tick(0, 0, 0, 0, OCI, "pos_reset_idle");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clockc2);
    #2;
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
